// File: rtl/reg_bank_ext.sv
// Parametrised register bank: NREG registers of WIDTH bits sharing one function
// select, two combinational read ports and a registered inc/dec overflow event.
module reg_bank_ext #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          NREG      = 4,
  parameter int unsigned          SATURATE  = 0,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               FunSel,
  input  logic [NREG-1:0]          RegSel,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(NREG)-1:0]  OutASel,
  input  logic [$clog2(NREG)-1:0]  OutBSel,
  output logic [WIDTH-1:0]         OutA,
  output logic [WIDTH-1:0]         OutB,
  output logic                     zero_a,
  output logic                     ovf
);

  localparam int unsigned SelW = $clog2(NREG);
  localparam int unsigned TblN = 1 << SelW;
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Ones = '1;

  logic [WIDTH-1:0] reg_q  [NREG];
  logic [WIDTH-1:0] reg_d  [NREG];
  logic [WIDTH-1:0] rd_tbl [TblN];
  logic             ovf_q, ovf_d;

  // Next-state for every register plus the overflow event for this edge.
  always_comb begin
    ovf_d = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      reg_d[i] = reg_q[i];
      if (RegSel[i]) begin
        case (FunSel)
          3'b000: reg_d[i] = '0;
          3'b001: reg_d[i] = data_in;
          3'b010: begin
            reg_d[i] = reg_q[i] - One;
            if (reg_q[i] == '0) begin
              ovf_d = 1'b1;
              if (SATURATE != 0) reg_d[i] = '0;
            end
          end
          3'b011: begin
            reg_d[i] = reg_q[i] + One;
            if (reg_q[i] == Ones) begin
              ovf_d = 1'b1;
              if (SATURATE != 0) reg_d[i] = Ones;
            end
          end
          3'b100: reg_d[i] = {reg_q[i][WIDTH-2:0], 1'b0};
          3'b101: reg_d[i] = {1'b0, reg_q[i][WIDTH-1:1]};
          3'b110: reg_d[i] = {reg_q[i][WIDTH-1], reg_q[i][WIDTH-1:1]};
          default: reg_d[i] = {reg_q[i][WIDTH-2:0], reg_q[i][WIDTH-1]};
        endcase
      end
    end
  end

  // State update; synchronous reset overrides any selected operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) reg_q[i] <= reg_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Read table padded to a power of two so unused indices read as zero.
  always_comb begin
    for (int unsigned j = 0; j < TblN; j++) rd_tbl[j] = '0;
    for (int unsigned j = 0; j < NREG; j++) rd_tbl[j] = reg_q[j];
  end

  // Combinational read ports, no write bypass.
  always_comb begin
    OutA   = rd_tbl[OutASel];
    OutB   = rd_tbl[OutBSel];
    zero_a = (OutA == '0);
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_reg_bank_ext.sv
// Scoreboard bench for reg_bank_ext: three instances (wrapping, saturating,
// three-register) driven by directed vectors with hand-computed expectations.
module tb_reg_bank_ext;

  localparam int KA = 0;  // OutA
  localparam int KB = 1;  // OutB
  localparam int KZ = 2;  // zero_a
  localparam int KO = 3;  // ovf

  typedef struct {
    int         k;
    int         kind;
    logic [3:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0][2:0]  fs;
  logic [2:0][3:0]  rs;
  logic [2:0][3:0]  din;
  logic [2:0][1:0]  as;
  logic [2:0][1:0]  bs;

  logic [3:0] oa0, oa1, oa2, ob0, ob1, ob2;
  logic       za0, za1, za2, ov0, ov1, ov2;

  reg_bank_ext #(.WIDTH(4), .NREG(4), .SATURATE(0), .RESET_VAL(4'h5)) u_wrap (
    .clk(clk), .rst(rst[0]), .FunSel(fs[0]), .RegSel(rs[0]), .data_in(din[0]),
    .OutASel(as[0]), .OutBSel(bs[0]), .OutA(oa0), .OutB(ob0), .zero_a(za0), .ovf(ov0)
  );

  reg_bank_ext #(.WIDTH(4), .NREG(4), .SATURATE(1), .RESET_VAL(4'h0)) u_sat (
    .clk(clk), .rst(rst[1]), .FunSel(fs[1]), .RegSel(rs[1]), .data_in(din[1]),
    .OutASel(as[1]), .OutBSel(bs[1]), .OutA(oa1), .OutB(ob1), .zero_a(za1), .ovf(ov1)
  );

  reg_bank_ext #(.WIDTH(4), .NREG(3), .SATURATE(0), .RESET_VAL(4'h0)) u_n3 (
    .clk(clk), .rst(rst[2]), .FunSel(fs[2]), .RegSel(rs[2][2:0]), .data_in(din[2]),
    .OutASel(as[2]), .OutBSel(bs[2]), .OutA(oa2), .OutB(ob2), .zero_a(za2), .ovf(ov2)
  );

  function automatic logic [3:0] pick(input int k, input int kind);
    logic [3:0] r;
    r = 4'h0;
    case (k)
      0: case (kind) KA: r = oa0; KB: r = ob0; KZ: r = {3'b0, za0}; default: r = {3'b0, ov0}; endcase
      1: case (kind) KA: r = oa1; KB: r = ob1; KZ: r = {3'b0, za1}; default: r = {3'b0, ov1}; endcase
      default: case (kind) KA: r = oa2; KB: r = ob2; KZ: r = {3'b0, za2}; default: r = {3'b0, ov2}; endcase
    endcase
    return r;
  endfunction

  // Monitor: drain every expectation queued for this cycle at the falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = pick(e.k, e.kind);
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  // Drive one cycle of inputs for instance k, just after the rising edge.
  task automatic cyc(input int k, input logic r, input logic [2:0] f, input logic [3:0] s,
                     input logic [3:0] d, input logic [1:0] a, input logic [1:0] b);
    @(posedge clk);
    #1;
    rst[k] = r; fs[k] = f; rs[k] = s; din[k] = d; as[k] = a; bs[k] = b;
  endtask

  task automatic chk(input int k, input int kind, input logic [3:0] v, input string nm);
    exp_t e;
    e.k = k; e.kind = kind; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 3'b111; fs = '0; rs = '0; din = '0; as = '0; bs = '0;

    // Wrapping bank, reset value 5.
    cyc(0, 1, 3'b001, 4'b1111, 4'hF, 2'd0, 2'd1);
    cyc(0, 1, 3'b001, 4'b1111, 4'hF, 2'd0, 2'd1);
    chk(0, KA, 4'h5, "w_rst_r0"); chk(0, KB, 4'h5, "w_rst_r1"); chk(0, KO, 4'h0, "w_rst_ovf");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'h5, "w_rstwin_r2"); chk(0, KB, 4'h5, "w_rstwin_r3"); chk(0, KZ, 4'h0, "w_rst_za");
    cyc(0, 0, 3'b001, 4'b0010, 4'hA, 2'd1, 2'd0);
    chk(0, KA, 4'h5, "w_r1_before_load");
    cyc(0, 0, 3'b100, 4'b0010, 4'h0, 2'd1, 2'd0);
    chk(0, KA, 4'hA, "w_load_A");
    cyc(0, 0, 3'b001, 4'b0010, 4'hA, 2'd1, 2'd0);
    chk(0, KA, 4'h4, "w_shl");
    cyc(0, 0, 3'b111, 4'b0010, 4'h0, 2'd1, 2'd0);
    chk(0, KA, 4'hA, "w_reload1");
    cyc(0, 0, 3'b001, 4'b0010, 4'hA, 2'd1, 2'd0);
    chk(0, KA, 4'h5, "w_rotl");
    cyc(0, 0, 3'b110, 4'b0010, 4'h0, 2'd1, 2'd0);
    chk(0, KA, 4'hA, "w_reload2");
    cyc(0, 0, 3'b001, 4'b0010, 4'hA, 2'd1, 2'd0);
    chk(0, KA, 4'hD, "w_asr"); chk(0, KO, 4'h0, "w_asr_ovf");
    cyc(0, 0, 3'b101, 4'b0010, 4'h0, 2'd1, 2'd0);
    chk(0, KA, 4'hA, "w_reload3");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd1, 2'd0);
    chk(0, KA, 4'h5, "w_lsr"); chk(0, KB, 4'h5, "w_r0_kept"); chk(0, KO, 4'h0, "w_shift_ovf");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'h5, "w_r2_kept"); chk(0, KB, 4'h5, "w_r3_kept");

    // Wrap-around overflow pulses.
    cyc(0, 0, 3'b001, 4'b0100, 4'hF, 2'd2, 2'd3);
    chk(0, KA, 4'h5, "w_r2_preload");
    cyc(0, 0, 3'b011, 4'b0100, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'hF, "w_r2_F"); chk(0, KO, 4'h0, "w_ovf_before_inc");
    cyc(0, 0, 3'b010, 4'b0100, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'h0, "w_inc_wrap"); chk(0, KZ, 4'h1, "w_inc_wrap_za");
    chk(0, KO, 4'h1, "w_inc_wrap_ovf");
    cyc(0, 0, 3'b001, 4'b0100, 4'h3, 2'd2, 2'd3);
    chk(0, KA, 4'hF, "w_dec_wrap"); chk(0, KO, 4'h1, "w_dec_wrap_ovf");
    cyc(0, 0, 3'b011, 4'b0100, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'h3, "w_load3"); chk(0, KO, 4'h0, "w_ovf_pulse_end");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'h4, "w_inc3"); chk(0, KO, 4'h0, "w_inc3_ovf"); chk(0, KZ, 4'h0, "w_inc3_za");

    // All four selected: R0..R3 = 0,1,E,F then increment together.
    cyc(0, 0, 3'b000, 4'b0001, 4'h0, 2'd0, 2'd1);
    cyc(0, 0, 3'b001, 4'b0010, 4'h1, 2'd0, 2'd1);
    chk(0, KA, 4'h0, "w_r0_clr"); chk(0, KZ, 4'h1, "w_r0_clr_za");
    cyc(0, 0, 3'b001, 4'b0100, 4'hE, 2'd0, 2'd1);
    cyc(0, 0, 3'b001, 4'b1000, 4'hF, 2'd0, 2'd1);
    cyc(0, 0, 3'b011, 4'b1111, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'hE, "w_multi_old_r2"); chk(0, KB, 4'hF, "w_multi_old_r3");
    chk(0, KO, 4'h0, "w_multi_pre_ovf");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd0, 2'd1);
    chk(0, KA, 4'h1, "w_multi_r0"); chk(0, KB, 4'h2, "w_multi_r1");
    chk(0, KO, 4'h1, "w_multi_ovf");
    cyc(0, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd3);
    chk(0, KA, 4'hF, "w_multi_r2"); chk(0, KB, 4'h0, "w_multi_r3");
    chk(0, KO, 4'h0, "w_multi_ovf_end");

    // Saturating bank, reset value 0.
    cyc(1, 0, 3'b001, 4'b0100, 4'hF, 2'd2, 2'd0);
    chk(1, KA, 4'h0, "s_rst"); chk(1, KZ, 4'h1, "s_rst_za"); chk(1, KO, 4'h0, "s_rst_ovf");
    cyc(1, 0, 3'b011, 4'b0100, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'hF, "s_load_F");
    cyc(1, 0, 3'b000, 4'b0100, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'hF, "s_inc_sat"); chk(1, KO, 4'h1, "s_inc_sat_ovf");
    cyc(1, 0, 3'b010, 4'b0100, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'h0, "s_clr"); chk(1, KO, 4'h0, "s_clr_ovf");
    cyc(1, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'h0, "s_dec_sat"); chk(1, KZ, 4'h1, "s_dec_sat_za");
    chk(1, KO, 4'h1, "s_dec_sat_ovf");
    cyc(1, 0, 3'b001, 4'b0100, 4'hE, 2'd2, 2'd0);
    chk(1, KO, 4'h0, "s_ovf_end");
    cyc(1, 0, 3'b011, 4'b0100, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'hE, "s_load_E");
    cyc(1, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd0);
    chk(1, KA, 4'hF, "s_inc_E"); chk(1, KO, 4'h0, "s_inc_E_ovf");

    // Three-register bank: out-of-range read index and idle cycles.
    cyc(2, 0, 3'b000, 4'b0000, 4'h0, 2'd3, 2'd3);
    chk(2, KA, 4'h0, "n3_a_oor"); chk(2, KZ, 4'h1, "n3_za_oor"); chk(2, KB, 4'h0, "n3_b_oor");
    cyc(2, 0, 3'b001, 4'b0100, 4'h9, 2'd2, 2'd3);
    cyc(2, 0, 3'b000, 4'b0000, 4'h0, 2'd2, 2'd3);
    chk(2, KA, 4'h9, "n3_r2_load"); chk(2, KB, 4'h0, "n3_b_oor2");
    chk(2, KZ, 4'h0, "n3_za");
    for (int i = 0; i < 10; i++) begin
      cyc(2, 0, 3'($urandom_range(7)), 4'b0000, 4'($urandom_range(15)), 2'(i % 3), 2'd2);
      chk(2, KA, (i % 3 == 2) ? 4'h9 : 4'h0, $sformatf("n3_idle_a_%0d", i));
      chk(2, KB, 4'h9, $sformatf("n3_idle_b_%0d", i));
      chk(2, KO, 4'h0, $sformatf("n3_idle_ovf_%0d", i));
    end
    cyc(2, 0, 3'b000, 4'b0000, 4'h0, 2'd0, 2'd2);
    chk(2, KA, 4'h0, "n3_final_r0"); chk(2, KB, 4'h9, "n3_final_r2");
    chk(2, KO, 4'h0, "n3_final_ovf");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_ext.md
Name: reg_bank_ext

Overview:
Parametrised multi-register bank. It succeeds the single 4-bit clear/load/decrement/increment register with enable. NREG registers of WIDTH bits share one 3-bit function select, and a one-hot-capable select vector chooses which registers update. The bank adds shift and rotate operations, optional saturating arithmetic, two combinational read ports, and a registered overflow/underflow event flag. It is the general-purpose and address register bank for the datapath.

Parameters:
WIDTH, 8, bit width of each register (>=2)
NREG, 4, number of registers (2..16)
SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones/zero
RESET_VAL, 0, value loaded into every register on reset (WIDTH bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
FunSel  input  3  operation applied to every selected register
RegSel  input  NREG  bit i = 1 enables register i this cycle
data_in  input  WIDTH  load data
OutASel  input  clog2(NREG)  read port A register index
OutBSel  input  clog2(NREG)  read port B register index
OutA  output  WIDTH  contents of register OutASel
OutB  output  WIDTH  contents of register OutBSel
zero_a  output  1  1 when OutA == 0
ovf  output  1  registered event flag: inc/dec wrapped or saturated last cycle

Behaviour:
- One clock; reset is synchronous and active-high: on rising clk with rst=1, all registers <= RESET_VAL and ovf <= 0. rst dominates RegSel/FunSel.
- Register i with RegSel[i]=0 holds its value.
- FunSel encoding, applied to each selected register R:
  - 000: clear, R <= 0
  - 001: load, R <= data_in
  - 010: decrement
  - 011: increment
  - 100: logical shift left by 1, 0 in at LSB
  - 101: logical shift right by 1, 0 in at MSB
  - 110: arithmetic shift right by 1, MSB replicated
  - 111: rotate left by 1, MSB moves to LSB
- Inc/dec with SATURATE=0: modulo 2^WIDTH. With SATURATE=1: inc of all-ones holds all-ones; dec of 0 holds 0.
- Multiple RegSel bits set: every selected register applies the same FunSel to its own current value. A load writes data_in to all of them.
- ovf <= 1 on the edge where any selected register gets inc at all-ones or dec at 0, in either SATURATE mode. Otherwise ovf <= 0.
- ovf is a single-cycle pulse, visible the cycle after the offending edge. Shifts and rotates never set ovf.
- Read ports: OutA/OutB are combinational from current register state (no bypass). A write becomes visible on the port the cycle after its edge; 0-cycle latency from OutxSel change.
- OutxSel >= NREG (NREG not a power of 2): the port drives 0, and zero_a = 1 for port A.
- zero_a is combinational from OutA.
- Illegal or unknown values are not required to be handled beyond the rules above. There is no X-propagation requirement.

Test Plan:
- WIDTH=4, NREG=4: rst=1 one cycle with RESET_VAL=4'h5 -> OutA=5 for all OutASel 0..3, ovf=0. Assert rst together with RegSel=1111, FunSel=001 -> reset value wins.
- Load 4'hA into R1 (RegSel=0010, FunSel=001), then FunSel=100 -> R1=4; FunSel=111 from A -> 5; FunSel=110 from A -> D; FunSel=101 from A -> 5; R0, R2, R3 unchanged.
- SATURATE=0: load F into R2, inc -> R2=0, ovf=1 the next cycle only. Dec from 0 -> F, ovf=1. Inc 3 -> 4, ovf=0.
- SATURATE=1: inc from F -> F with ovf=1; dec from 0 -> 0 with ovf=1, zero_a=1 when OutASel=2.
- RegSel=1111, FunSel=011 with R0..R3 = 0,1,E,F -> 1,2,F,0, ovf=1. Same cycle, OutA/OutB show old values until after the edge.
- NREG=3, OutBSel=3 -> OutB=0. Alternate RegSel=0000 with random FunSel for 10 cycles -> no register changes, ovf stays 0.
